// File: rtl/pool_window_buffer.sv
// Sliding-window buffer between the PE array and the pooling unit: circular element store,
// stride-S windows of P lanes. Define POOL_PAD_EN to zero-pad the final partial window of a layer.
module pool_window_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int PMAX  = 7
) (
    input  logic               clk_cal,
    input  logic               rst_cal_n,
    input  logic               layer_clr,
    input  logic [2:0]         cfg_p,
    input  logic [1:0]         cfg_s,
    input  logic [DW-1:0]      in_data,
    input  logic               in_vld,
    input  logic               in_last,
    output logic               in_rdy,
    output logic [PMAX*DW-1:0] win_data,
    output logic               win_vld,
    output logic               win_last,
    input  logic               win_rdy,
    output logic               layer_done,
    output logic               cfg_err,
    output logic               ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and win_data/win_last hold while win_vld=1 and win_rdy=0.

    logic [DW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [OW-1:0]      occ;
    logic               tail, done_q;
    logic [2:0]         p_q;
    logic [1:0]         s_q;
    logic [OW-1:0]      p_o, s_o, resid, n_lanes;
    logic               cfg_ok, wr, out_free, load_full, load_pad, load, tail_eff, last_full;
    logic [PMAX*DW-1:0] nxt_win;

    assign p_o      = OW'(p_q);
    assign s_o      = OW'(s_q);
    assign cfg_ok   = (p_q != 3'd0) && (p_o <= OW'(PMAX)) && (s_q != 2'd0) && (s_o <= p_o);
    assign cfg_err  = !cfg_ok;
    assign in_rdy   = (occ < OW'(DEPTH));
    assign wr       = in_vld && in_rdy;
    assign out_free = !win_vld || win_rdy;
    assign load_full = cfg_ok && out_free && (occ >= p_o);
    // An in_last accepted alongside a load already belongs to the tail of the layer.
    assign tail_eff = tail || (wr && in_last);
    assign resid    = occ + OW'(wr) - s_o;
    assign load     = load_full || load_pad;

`ifdef POOL_PAD_EN
    logic first;

    // A pad window is only worth emitting if some residual element never appeared in a window.
    assign load_pad  = cfg_ok && out_free && tail && (occ != '0) && (occ < p_o) &&
                       (first || (occ > p_o - s_o));
    assign last_full = tail_eff && (resid <= p_o - s_o);
    assign n_lanes   = load_pad ? occ : p_o;

    always_ff @(posedge clk_cal or negedge rst_cal_n) begin
        if (!rst_cal_n)     first <= 1'b1;
        else if (layer_clr) first <= 1'b1;
        else if (load)      first <= 1'b0;
    end
`else
    assign load_pad  = 1'b0;
    assign last_full = tail_eff && (resid < p_o);
    assign n_lanes   = p_o;
`endif

    always_comb begin
        logic [AW-1:0] idx;
        nxt_win = '0;
        idx     = '0;
        for (int i = 0; i < PMAX; i++) begin
            idx = rptr + AW'(i);
            if (OW'(i) < n_lanes) nxt_win[i*DW +: DW] = mem[idx];
        end
    end

    always_ff @(posedge clk_cal) begin
        if (wr && !layer_clr) mem[wptr] <= in_data;
    end

    always_ff @(posedge clk_cal or negedge rst_cal_n) begin
        if (!rst_cal_n) begin
            wptr       <= '0;
            rptr       <= '0;
            occ        <= '0;
            tail       <= 1'b0;
            done_q     <= 1'b0;
            p_q        <= '0;
            s_q        <= '0;
            win_data   <= '0;
            win_vld    <= 1'b0;
            win_last   <= 1'b0;
            layer_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else if (layer_clr) begin
            p_q        <= cfg_p;
            s_q        <= cfg_s;
            wptr       <= '0;
            rptr       <= '0;
            occ        <= '0;
            tail       <= 1'b0;
            done_q     <= 1'b0;
            win_vld    <= 1'b0;
            win_last   <= 1'b0;
            layer_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if (in_vld && !in_rdy) ovf_err <= 1'b1;
            if (wr) wptr <= wptr + AW'(1);
            if (wr && in_last) tail <= 1'b1;

            if (load_full) begin
                rptr <= rptr + AW'(s_q);
                occ  <= occ + OW'(wr) - s_o;
            end else if (load_pad) begin
                rptr <= rptr + occ[AW-1:0];
                occ  <= '0;
            end else begin
                occ  <= occ + OW'(wr);
            end

            if (load) begin
                win_data <= nxt_win;
                win_vld  <= 1'b1;
                win_last <= load_pad || last_full;
            end else if (win_rdy) begin
                win_vld  <= 1'b0;
                win_last <= 1'b0;
            end

            // Done fires once: after the last window is taken, or when the tail leaves nothing to emit.
            if (win_vld && win_rdy && win_last) begin
                layer_done <= 1'b1;
                done_q     <= 1'b1;
            end else if (tail && !win_vld && !load && !done_q) begin
                layer_done <= 1'b1;
                done_q     <= 1'b1;
            end
        end
    end
endmodule

// File: doc/pool_window_buffer.md
# pool_window_buffer

Parametrised sliding-window buffer between the PE array output and the pooling unit of the ECG accelerator. It collects the byte stream produced by the PE array into a circular register file. It emits packed windows of `P` consecutive elements that advance by stride `S`, with full ready/valid handshaking on both sides and wrap-around handled in the address path. Optionally, the final partial window of a layer is zero-padded.

## Interface
- `DW`, 8: element width in bits.
- `DEPTH`, 32: buffer entries; power of two, must be ≥ `PMAX`.
- `PMAX`, 7: maximum window length; sets the output bus width.
- `clk_cal` in 1: clock.
- `rst_cal_n` in 1: reset, asynchronous, active-low.
- `layer_clr` in 1: synchronous layer restart; also latches the configuration.
- `cfg_p` in 3: window length `P`.
- `cfg_s` in 2: stride `S`.
- `in_data` in DW: PE output element.
- `in_vld` in 1: element valid.
- `in_last` in 1: final element of the layer; qualified by `in_vld & in_rdy`.
- `in_rdy` out 1: buffer can accept an element.
- `win_data` out PMAX*DW: lane i = bits [i*DW +: DW], element base+i.
- `win_vld` out 1: window valid.
- `win_last` out 1: last window of the layer; qualified by `win_vld`.
- `win_rdy` in 1: consumer accepts the window.
- `layer_done` out 1: one-cycle pulse when the layer is fully drained.
- `cfg_err` out 1: latched configuration is invalid.
- `ovf_err` out 1: sticky; a write was attempted while full.

## Operation
- Configuration handling:
  - `cfg_p` and `cfg_s` are latched on the `layer_clr` cycle. The latched values reset to 0.
  - The configuration is valid iff 1 ≤ P ≤ PMAX and 1 ≤ S ≤ P.
  - While the configuration is invalid, `cfg_err`=1 and no window is emitted. Writes are still accepted.
- State:
  - Pointers: `wptr` and `rptr`, each log2(DEPTH) bits, both wrapping modulo DEPTH.
  - `occ`: log2(DEPTH)+1 bits; the number of buffered elements not yet retired.
  - Flags: `tail` (an `in_last` has been accepted) and `first` (no window emitted yet this layer).
- Write path:
  - `in_rdy` = (occ < DEPTH).
  - An accepted write stores to `buf[wptr]`, increments `wptr`, and adds 1 to `occ`.
  - `in_vld` while `in_rdy`=0 drops the data and sets `ovf_err`.
- Window load:
  - The output register loads when the configuration is valid, (!win_vld | win_rdy), and occ ≥ P.
  - On load, lane i = buf[(rptr+i) mod DEPTH] for i < P. Lanes ≥ P are 0.
  - On load, `rptr` += S, `occ` −= S, and `first` is cleared.
- Simultaneous events:
  - A write and a load in the same cycle give occ = occ + 1 − S.
  - A load happens in the same cycle as the accept of the previous window, giving back-to-back windows.
- `win_last`: set on a load when `tail`=1 and no further window is possible after the load. See Configuration.
- `layer_done`: pulses the cycle after the `win_last` window is accepted. If `tail`=1, no window is pending and none is possible, it pulses once at that point instead.
- `layer_clr`: highest priority. It clears the pointers, `occ`, `win_vld`, `win_last`, `tail` and `ovf_err`, and sets `first`. An in-flight window is discarded.

## Timing
- Reset values:
  - All outputs are 0, except `in_rdy`=1 and `cfg_err`=1 (latched P=0).
  - Register file contents are don't-care.
- Latency: an element accepted in cycle k can complete a window whose `win_vld` rises in cycle k+2.
- `win_data` and `win_last` stay stable while `win_vld`=1 and `win_rdy`=0.
- `in_rdy` is combinational from registered `occ` only. There is no path from `win_rdy` to `in_rdy`.
- Throughput: one window per cycle while occ ≥ P and `win_rdy`=1.

## Configuration
- Macro `POOL_PAD_EN`.
- Defined:
  - When `tail`=1, 0 < occ < P, the output register is free, and a fresh element remains (`first`=1, or occ > P−S), a pad window loads.
  - The pad window takes lanes 0..occ−1 from the buffer and sets the remaining lanes to 0.
  - The pad window sets `win_last`=1 and forces `occ` to 0.
  - `win_last` is also set on a full window when the residual occ after the load leaves no fresh element.
- Undefined:
  - The residual elements are discarded.
  - `win_last` is set on the full window after which occ < P.
  - A layer with fewer than P elements emits no window; only `layer_done` pulses.

## Test plan
- P=7, S=2, bytes 0..15 with `in_last` on 15, `win_rdy`=1 → five windows with bases 0, 2, 4, 6, 8.
  - With `POOL_PAD_EN`: a sixth window {10..15, 0} with `win_last`.
  - Without it: `win_last` on base 8.
  - In both cases `layer_done` pulses once.
- Wrap-around: DEPTH=32, P=4, S=2, 40 bytes 0..39 → the window at base 30 is {30, 31, 32, 33}, read from addresses 30, 31, 0, 1.
- Backpressure: P=S=2, `win_rdy`=0, continuous `in_vld` → exactly 34 elements accepted, then `in_rdy`=0.
  - `win_data` holds {0, 1}.
  - Raising `win_rdy` drains windows {2, 3}, {4, 5}, … with no loss.
- Overflow: in the previous state, pulse `in_vld` with `in_rdy`=0 → `ovf_err`=1, the data is absent from all windows, and the flag clears on `layer_clr`.
- Invalid configuration: `layer_clr` with P=2, S=3 → `cfg_err`=1 and `win_vld` stays 0. A `layer_clr` with P=4, S=2 → `cfg_err`=0.
- Mid-layer `layer_clr` with `win_vld`=1 → the next cycle has `win_vld`=0, occ=0 and `in_rdy`=1; the new layer's first window is built from bytes written after the clear only.
